// File: rtl/pipe_mem_pkg.sv
// Shared types and default widths for the pipelined-CPU memory arbiter.
package pipe_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MEM_LAT    = 2;
   localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data memory (DM).
// DM has priority, IF is protected by a starvation counter, and an in-flight
// fetch can be cancelled by a branch flush without disturbing the memory access.
module pipe_mem_arbiter
   import pipe_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_if_o,
   output logic              stall_mem_o
);

   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

   state_t            state;
   state_t            state_nxt;
   owner_t            owner;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [LAT_W-1:0]  lat_cnt;
   logic [STV_W-1:0]  starve_cnt;
   logic              cancel;
   logic              if_ack_q;
   logic              dm_ack_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_q;
   logic              grant_if;
   logic              grant_dm;
   logic              if_wins;
   logic              flush_hit;

   // IF takes the port when DM is quiet or when DM has starved it long enough.
   assign if_wins   = if_req_i & (~dm_req_i | (starve_cnt == STARVE_TOP));
   assign flush_hit = if_flush_i & (owner == OWN_IF);

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the arbitration grant, which is only made in IDLE.
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      case (state)
         IDLE: begin
            if (if_req_i | dm_req_i) begin
               state_nxt = ISSUE;
               if (if_wins) begin
                  grant_if = 1'b1;
               end else begin
                  grant_dm = 1'b1;
               end
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (lat_cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction registers, counters, cancel flag, read-data capture and acks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner      <= OWN_IF;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         cancel     <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         case (state)
            IDLE: begin
               cancel <= 1'b0;
               if (grant_if) begin
                  owner      <= OWN_IF;
                  addr_q     <= if_addr_i;
                  we_q       <= 1'b0;
                  wdata_q    <= '0;
                  starve_cnt <= '0;
               end else if (grant_dm) begin
                  owner   <= OWN_DM;
                  addr_q  <= dm_addr_i;
                  we_q    <= dm_we_i;
                  wdata_q <= dm_wdata_i;
                  if (if_req_i && (starve_cnt != STARVE_TOP)) begin
                     starve_cnt <= starve_cnt + 1'b1;
                  end
               end
               if (!if_req_i) begin
                  starve_cnt <= '0;
               end
            end
            ISSUE: begin
               lat_cnt <= LAT_LOAD;
               if (flush_hit) begin
                  cancel <= 1'b1;
               end
            end
            WAIT: begin
               if (flush_hit) begin
                  cancel <= 1'b1;
               end
               if (lat_cnt == '0) begin
                  if (owner == OWN_DM) begin
                     dm_ack_q <= 1'b1;
                     if (!we_q) begin
                        dm_rdata_q <= mem_rdata_i;
                     end
                  end else if (!(cancel | flush_hit)) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_rdata_i;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RESP: begin
               cancel <= 1'b0;
            end
            default: begin
               cancel <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack_o    = if_ack_q;
   assign dm_ack_o    = dm_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign mem_en_o    = (state == ISSUE);
   assign mem_we_o    = (state == ISSUE) & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign stall_if_o  = if_req_i & ~if_ack_q;
   assign stall_mem_o = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter with MEM_LAT=2, STARVE_MAX=4.
// Memory model: returns 0x8C010004 for address 0x10, otherwise 0xA5000000 ^ addr.
module tb_pipe_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic [31:0] last_addr;

   int err_count   = 0;
   int check_count = 0;

   pipe_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem)
   );

   always #5 clk = ~clk;

   // Memory model: remember the issued address, data is valid until the next issue.
   always @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         last_addr <= 32'h0;
      end else if (mem_en) begin
         last_addr <= mem_addr;
      end
   end

   assign mem_rdata = (last_addr == 32'h10) ? 32'h8C010004 : (32'hA5000000 ^ last_addr);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe,
                                input logic [31:0] daddr, input logic [31:0] dwdata);
      if_req   = ireq;
      if_addr  = iaddr;
      dm_req   = dreq;
      dm_we    = dwe;
      dm_addr  = daddr;
      dm_wdata = dwdata;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // The two acks must never coincide.
   always @(negedge clk) begin
      if (!rst_i) begin
         checkOutput("ack_overlap", 32'(if_ack & dm_ack), 32'h0);
      end
   end

   initial begin
      int  dm_before;
      int  dm_after;
      bit  seen_if;
      logic [31:0] if_data_seen;

      rst_i    = 1'b1;
      if_flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(2);
      checkOutput("rst_if_ack",   32'(if_ack),   32'h0);
      checkOutput("rst_dm_ack",   32'(dm_ack),   32'h0);
      checkOutput("rst_mem_en",   32'(mem_en),   32'h0);
      checkOutput("rst_mem_addr", mem_addr,      32'h0);
      checkOutput("rst_if_rdata", if_rdata,      32'h0);
      rst_i = 1'b0;
      step(1);

      // Test 1: IF read from 0x10 (cycle T is this negedge)
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 checkOutput("t1_stall_T", 32'(stall_if), 32'h1);
      step(1);
      checkOutput("t1_mem_en",   32'(mem_en),   32'h1);
      checkOutput("t1_mem_we",   32'(mem_we),   32'h0);
      checkOutput("t1_mem_addr", mem_addr,      32'h10);
      step(2);
      checkOutput("t1_no_ack_T3", 32'(if_ack),   32'h0);
      checkOutput("t1_stall_T3",  32'(stall_if), 32'h1);
      step(1);
      checkOutput("t1_if_ack",   32'(if_ack),   32'h1);
      checkOutput("t1_if_rdata", if_rdata,      32'h8C010004);
      checkOutput("t1_stall_T4", 32'(stall_if), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);
      checkOutput("t1_ack_pulse", 32'(if_ack), 32'h0);

      // Test 2: IF 0x04 and DM read 0x20 together; DM first
      applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'h20, 32'h0);
      step(1);
      checkOutput("t2_dm_en",     32'(mem_en),    32'h1);
      checkOutput("t2_dm_addr",   mem_addr,       32'h20);
      checkOutput("t2_stall_mem", 32'(stall_mem), 32'h1);
      step(3);
      checkOutput("t2_dm_ack",    32'(dm_ack),    32'h1);
      checkOutput("t2_if_noack",  32'(if_ack),    32'h0);
      checkOutput("t2_dm_rdata",  dm_rdata,       32'hA5000020);
      checkOutput("t2_stall_mem0", 32'(stall_mem), 32'h0);
      dm_req = 1'b0;
      step(1);
      checkOutput("t2_idle_en",   32'(mem_en),    32'h0);
      step(1);
      checkOutput("t2_if_en",     32'(mem_en),    32'h1);
      checkOutput("t2_if_addr",   mem_addr,       32'h04);
      step(3);
      checkOutput("t2_if_ack",    32'(if_ack),    32'h1);
      checkOutput("t2_if_rdata",  if_rdata,       32'hA5000004);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);

      // Test 3: DM write 0xFF to 0x08
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 32'h000000FF);
      step(1);
      checkOutput("t3_mem_en",    32'(mem_en), 32'h1);
      checkOutput("t3_mem_we",    32'(mem_we), 32'h1);
      checkOutput("t3_mem_addr",  mem_addr,    32'h08);
      checkOutput("t3_mem_wdata", mem_wdata,   32'h000000FF);
      step(3);
      checkOutput("t3_dm_ack",    32'(dm_ack), 32'h1);
      checkOutput("t3_rdata_keep", dm_rdata,   32'hA5000020);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);
      checkOutput("t3_we_off",    32'(mem_we), 32'h0);

      // Test 4: starvation guard; IF waits through exactly 4 DM grants
      applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'h24, 32'h0);
      dm_before    = 0;
      dm_after     = 0;
      seen_if      = 1'b0;
      if_data_seen = 32'h0;
      for (int cyc = 0; cyc < 60 && dm_after == 0; cyc++) begin
         step(1);
         if (dm_ack) begin
            if (seen_if) dm_after++;
            else dm_before++;
         end
         if (if_ack) begin
            seen_if      = 1'b1;
            if_data_seen = if_rdata;
            if_req       = 1'b0;
         end
      end
      checkOutput("t4_dm_before_if", 32'(dm_before), 32'd4);
      checkOutput("t4_if_granted",   32'(seen_if),   32'h1);
      checkOutput("t4_if_rdata",     if_data_seen,   32'hA5000004);
      checkOutput("t4_dm_after_if",  32'(dm_after),  32'd1);
      checkOutput("t4_dm_rdata",     dm_rdata,       32'hA5000024);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);

      // Test 5: flush of an in-flight fetch to 0x30
      applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
      step(2);
      if_flush = 1'b1;
      if_req   = 1'b0;
      step(1);
      if_flush = 1'b0;
      checkOutput("t5_no_ack_T3", 32'(if_ack), 32'h0);
      step(1);
      checkOutput("t5_no_ack_T4", 32'(if_ack), 32'h0);
      checkOutput("t5_rdata_keep", if_rdata,   32'hA5000004);
      step(1);
      checkOutput("t5_no_ack_T5", 32'(if_ack), 32'h0);
      checkOutput("t5_idle_en",   32'(mem_en), 32'h0);
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);
      checkOutput("t5_new_en",    32'(mem_en), 32'h1);
      checkOutput("t5_new_addr",  mem_addr,    32'h40);
      step(3);
      checkOutput("t5_new_ack",   32'(if_ack), 32'h1);
      checkOutput("t5_new_rdata", if_rdata,    32'hA5000040);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1);

      // Test 6: asynchronous reset in the middle of WAIT
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
      step(2);
      rst_i  = 1'b1;
      dm_req = 1'b0;
      #1;
      checkOutput("t6_dm_ack",    32'(dm_ack),    32'h0);
      checkOutput("t6_if_ack",    32'(if_ack),    32'h0);
      checkOutput("t6_if_rdata",  if_rdata,       32'h0);
      checkOutput("t6_dm_rdata",  dm_rdata,       32'h0);
      checkOutput("t6_mem_en",    32'(mem_en),    32'h0);
      checkOutput("t6_mem_we",    32'(mem_we),    32'h0);
      checkOutput("t6_mem_addr",  mem_addr,       32'h0);
      checkOutput("t6_mem_wdata", mem_wdata,      32'h0);
      checkOutput("t6_stall_mem", 32'(stall_mem), 32'h0);
      step(2);
      checkOutput("t6_hold_ack",  32'(dm_ack),    32'h0);
      rst_i = 1'b0;
      step(1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
      step(1);
      checkOutput("t6_post_en",   32'(mem_en),    32'h1);
      checkOutput("t6_post_addr", mem_addr,       32'h60);
      step(2);
      checkOutput("t6_post_noack", 32'(dm_ack),   32'h0);
      step(1);
      checkOutput("t6_post_ack",  32'(dm_ack),    32'h1);
      checkOutput("t6_post_rdata", dm_rdata,      32'hA5000060);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(2);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
Arbitrates the single-port unified memory between the pipelined CPU's instruction-fetch (IF) port and its data-memory (DM) port. Runs a request/ack handshake towards each pipeline stage and produces stall signals for the hazard logic. A fixed-latency memory request sequence drives the memory port. Priority goes to DM, with a starvation guard for IF and a branch-flush cancel for fetches already in flight.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en_o cycle to valid mem_rdata_i (at least 1)
STARVE_MAX, 4, maximum consecutive DM grants while IF is waiting

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
if_req_i  in  1  fetch request; held until if_ack_o or if_flush_i
if_addr_i  in  ADDR_W  fetch address; stable while requested
if_flush_i  in  1  branch flush; cancels the pending fetch
if_ack_o  out  1  one-cycle fetch completion pulse
if_rdata_o  out  DATA_W  fetched instruction; valid with if_ack_o
dm_req_i  in  1  data request; held until dm_ack_o
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_ack_o  out  1  one-cycle data completion pulse
dm_rdata_o  out  DATA_W  read data; valid with dm_ack_o
mem_en_o  out  1  memory access strobe, one cycle per access
mem_we_o  out  1  memory write enable; qualified by mem_en_o
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data
stall_if_o  out  1  high when if_req_i & ~if_ack_o
stall_mem_o  out  1  high when dm_req_i & ~dm_ack_o

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is sampled high at a rising edge, go to ISSUE.
  - Latch the owner, address, we and wdata into registers.
  - The latched values must stay stable through RESP.
- Arbitration, decided in IDLE only:
  - IF wins when dm_req_i = 0.
  - IF also wins when starve_cnt == STARVE_MAX and if_req_i = 1.
  - DM wins in every other case.
- starve_cnt:
  - Increments on each DM grant made while if_req_i = 1.
  - Clears to 0 on an IF grant, and when if_req_i = 0 in IDLE.
  - Saturates at STARVE_MAX.
- ISSUE (one cycle):
  - mem_en_o = 1, and mem_we_o = latched we.
  - mem_addr_o and mem_wdata_o come from the latched registers.
  - Next state is WAIT, with lat_cnt loaded to MEM_LAT-1.
- WAIT:
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0, mem_rdata_i is valid: capture it into the owner's rdata register and go to RESP.
- RESP (one cycle):
  - The owner's ack is registered high; the other ack stays 0.
  - Next state is IDLE. Requests are ignored in RESP because the requester still holds req in the ack cycle.
- Latency:
  - Request sampled in cycle T gives mem_en_o in T+1 and ack in T+MEM_LAT+2.
  - Throughput is one access per MEM_LAT+3 cycles.
- Writes:
  - The ack is asserted as for reads.
  - dm_rdata_o keeps its previous value.
- Flush:
  - if_flush_i = 1 while the IF owner is in ISSUE or WAIT sets a cancel flag.
  - The memory access still completes, but if_ack_o is suppressed and if_rdata_o is not updated.
  - The FSM then returns to IDLE.
  - Flush in IDLE, or during a DM transaction, has no effect.
  - Flush in the RESP cycle does not retract an ack that is already asserted.
- The two acks are never high in the same cycle. mem_en_o is high in ISSUE only.
- Reset, asynchronous, including mid-transaction:
  - State goes to IDLE and the in-flight access is dropped with no ack; requesters re-request.
  - Every output clears to 0: acks, rdata registers, mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o.
  - starve_cnt, lat_cnt and the cancel flag clear to 0.
- The stall outputs are combinational from req and ack.

Decomposition:
- Package pipe_mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner enum (OWN_IF/OWN_DM);
  - default widths.
- No sub-module: the latency counter and starvation counter are a few lines each, so the block stays flat.

Test Plan:
(Parameters MEM_LAT = 2, STARVE_MAX = 4; T is the cycle the request is first sampled.)
1. IF read from 0x10, memory returns 0x8C010004 -> mem_en_o=1, mem_we_o=0, mem_addr_o=0x10 in T+1; if_ack_o=1 and if_rdata_o=0x8C010004 in T+4; stall_if_o high T..T+3.
2. IF to 0x04 and DM read to 0x20 requested in the same cycle T -> DM issued in T+1 with dm_ack_o in T+4; IF issued in T+6 with if_ack_o in T+9; the acks never overlap.
3. DM write of 0x000000FF to 0x08 -> in T+1, mem_we_o=1 and mem_wdata_o=0xFF; dm_ack_o in T+4; dm_rdata_o unchanged.
4. if_req_i held with dm_req_i re-asserted after every ack -> exactly 4 DM grants, then an IF grant; starve_cnt returns to 0 and DM is served next.
5. IF to 0x30, if_flush_i pulsed in T+2 -> no if_ack_o; FSM back in IDLE at T+5; a new IF request to 0x40 then completes normally with its data.
6. rst_i asserted mid-WAIT -> all outputs 0 immediately with no ack; after reset release a fresh DM read completes with the standard latency.
